enemy2_datapath: RTL and testbench
==================================

# enemy2_datapath

Datapath paired with the enemy-2 control FSM. It holds the enemy sprite's position and colour and sweeps a 4x4 pixel block. It generates the pixel-count and delay-count status the FSM branches on, and drives the pixel bus (x, y, colour, plot) into the VGA adapter. Each cycle it consumes the FSM's one-hot control strobes and returns `cnt`, `delay_cnt`, `X` and `Y`.

## Interface
Parameters:
- `X_INIT`, 8'd20: x position after reset or `en_reset`.
- `Y_INIT`, 7'd0: y position after reset, `en_reset` or bottom wrap.
- `Y_BOTTOM`, 7'd110: last y row before wrap.
- `X_MAX`, 8'd156: largest legal sprite x, so that x+3 ≤ 159.
- `PRESCALE_W`, 20: width of the delay prescaler. One `delay_cnt` tick every 2^PRESCALE_W enabled cycles.
- `LFSR_SEED`, 8'hA5: LFSR value after reset. Must be nonzero.

Ports:
- `clock`, in, 1: sole clock.
- `resetn`, in, 1: synchronous, active-low reset.
- `choice`, in, 1: lane select.
- `num`, in, 2: lane number. The block updates only when `num[0]==choice` (the lane enable, `en`).
- `colour_in`, in, 3: sprite colour, captured on `load_colour`.
- `loadX`, `loadY`, `load_colour`, `load_black`, in, 1 each: FSM strobes.
- `plot`, in, 1: FSM plot request.
- `en_counter`, in, 1: advance the pixel counter.
- `en_delay_counter`, in, 1: advance the delay prescaler.
- `reset_delay`, in, 1: delay arm. 0 holds the prescaler and `delay_cnt` at zero.
- `en_reset`, in, 1: return the sprite to its start position.
- `X`, out, 8: sprite x register.
- `Y`, out, 7: sprite y register.
- `cnt`, out, 4: pixel counter.
- `delay_cnt`, out, 4: delay counter.
- `vga_x`, out, 8: pixel x, registered.
- `vga_y`, out, 7: pixel y, registered.
- `vga_colour`, out, 3: pixel colour, registered.
- `vga_plot`, out, 1: pixel write strobe, registered.

## Operation
- **Reset.** `resetn` low at a clock edge forces:
  - `X=X_INIT`, `Y=Y_INIT`;
  - colour register = 0;
  - `cnt=0`, `delay_cnt=0`, prescaler = 0;
  - LFSR = `LFSR_SEED`;
  - `vga_x=0`, `vga_y=0`, `vga_colour=0`, `vga_plot=0`.
  Reset acts regardless of `en`.
- **Lane gating.** When `en=0`, every register holds and `vga_plot` is forced to 0 on that cycle.
- **`en_reset`.** Sets `X=X_INIT`, `Y=Y_INIT`, `cnt=0`, and clears the delay. The colour register and LFSR keep their values. `en_reset` overrides `loadX`/`loadY` in the same cycle.
- **`loadY`.** If `Y==Y_BOTTOM`, `Y <= Y_INIT`; otherwise `Y <= Y+1`.
- **`loadX`.** `X <= (lfsr > X_MAX) ? lfsr − (X_MAX+1) : lfsr`, using the LFSR value before this cycle's advance.
- **`loadX` and `loadY` together.** Both apply. Gating `loadX` on the bottom row is the FSM's job; this block does not check it.
- **`load_colour`.** Colour register <= `colour_in`.
- **LFSR.** 8-bit Galois, polynomial x^8+x^6+x^5+x^4+1. Advances every enabled cycle and never reaches 0.
- **`cnt`.** Increments when `en_counter=1` and wraps 15→0.
- **Delay counter.**
  - When `reset_delay=0`: prescaler and `delay_cnt` clear.
  - Else, when `en_delay_counter=1`: the prescaler increments. On prescaler wrap, `delay_cnt` increments and saturates at 15.
- **Pixel address.** `px = X + cnt[1:0]`, `py = Y + cnt[3:2]`. Both stay in range: `X ≤ X_MAX`, and y is held in range by the wrap.
- **Pixel colour.** 3'b000 when `load_black=1`, else the colour register.

## Timing
- The `vga_*` outputs are registered from `px`, `py`, the pixel colour and `plot`, giving a latency of 1 cycle. They are updated every enabled cycle.
- The combinational next-state of `cnt` is not exposed. The FSM samples the registered `cnt`, so `cnt==15` is seen on the 16th plot cycle, and `cnt` returns to 0 on the following edge.
- Delay: with `reset_delay=en_delay_counter=1` held, `delay_cnt` reaches 15 after 15·2^PRESCALE_W cycles.
- `X`, `Y`, `cnt` and `delay_cnt` are direct register outputs with no extra latency.

## Structure
- Shared package `game_pkg`:
  - `SCREEN_W=160`, `SCREEN_H=120`;
  - `SPRITE_DIM=4`;
  - `COLOUR_BLACK=3'b000`;
  - 3-bit colour type.
- One sub-module: `enemy_lfsr`, holding the 8-bit Galois LFSR with seed parameter, enable and synchronous reset.

## Test plan
- **Reset.** Hold `resetn=0` for 2 cycles → `X=20`, `Y=0`, `cnt=0`, `delay_cnt=0`, `vga_plot=0`.
- **Draw.** `colour_in=3'b100`, pulse `load_colour`; preset `Y=5`; hold `plot=en_counter=1` for 16 cycles → `vga_(x,y)` steps (20,5),(21,5)…(23,8) one cycle after each `cnt`, colour 100; `cnt` wraps to 0.
- **Erase.** Repeat the draw with `load_black=1` → the same 16 coordinates, `vga_colour=000`.
- **Delay.** Bench `PRESCALE_W=2`. `reset_delay=en_delay_counter=1` → `delay_cnt=15` at cycle 60 and stays 15. Drop `reset_delay` → 0 the next cycle.
- **Bottom wrap.** `Y=110`, pulse `loadX`+`loadY` → `Y=0`, `X ≤ 156`, and `X` equals the mapped pre-advance LFSR value. Also check `en_reset` together with `loadY` → `Y=0`, `X=20`.
- **Lane gating and reset mid-operation.**
  - With `num=2'b01`, `choice=0`, pulse all strobes → no register changes and `vga_plot=0`.
  - Assert `resetn=0` at `cnt=7` mid-draw → all reset values on the next edge.

Source files
------------

// File: rtl/game_pkg.sv
// ============================================================================
// Module      : game_pkg
// Description : Screen geometry, sprite size and colour type shared by sprites.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package game_pkg;

    localparam int SCREEN_W   = 160;
    localparam int SCREEN_H   = 120;
    localparam int SPRITE_DIM = 4;

    typedef logic [2:0] colour_t;

    localparam colour_t COLOUR_BLACK = 3'b000;

endpackage

`default_nettype wire

// File: rtl/enemy_lfsr.sv
// ============================================================================
// Module      : enemy_lfsr
// Description : 8-bit Galois LFSR, x^8+x^6+x^5+x^4+1, steps once per enable.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module enemy_lfsr #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       en_i,
    output logic [7:0] lfsr_o
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    // Right-shifting Galois form: the bit shifted out is folded into taps 7,5,4,3.
    always_comb begin
        lfsr_d = lfsr_q;
        if (en_i) begin
            lfsr_d = {lfsr_q[0],
                      lfsr_q[7],
                      lfsr_q[6] ^ lfsr_q[0],
                      lfsr_q[5] ^ lfsr_q[0],
                      lfsr_q[4] ^ lfsr_q[0],
                      lfsr_q[3],
                      lfsr_q[2],
                      lfsr_q[1]};
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

`default_nettype wire

// File: rtl/enemy2_datapath.sv
// ============================================================================
// Module      : enemy2_datapath
// Description : Enemy-2 sprite position/colour, 4x4 pixel sweep, delay timer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module enemy2_datapath
    import game_pkg::*;
#(
    parameter logic [7:0] X_INIT     = 8'd20,
    parameter logic [6:0] Y_INIT     = 7'd0,
    parameter logic [6:0] Y_BOTTOM   = 7'd110,
    parameter logic [7:0] X_MAX      = 8'd156,
    parameter int         PRESCALE_W = 20,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       choice,
    input  logic [1:0] num,
    input  logic [2:0] colour_in,
    input  logic       loadX,
    input  logic       loadY,
    input  logic       load_colour,
    input  logic       load_black,
    input  logic       plot,
    input  logic       en_counter,
    input  logic       en_delay_counter,
    input  logic       reset_delay,
    input  logic       en_reset,
    output logic [7:0] X,
    output logic [6:0] Y,
    output logic [3:0] cnt,
    output logic [3:0] delay_cnt,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);

    localparam logic [7:0] c_X_SPAN = X_MAX + 8'd1;

    logic                  en;
    logic [7:0]            lfsr;
    logic [7:0]            x_rand;
    logic [7:0]            px;
    logic [6:0]            py;
    colour_t               pix_colour;

    logic [7:0]            x_q,         x_d;
    logic [6:0]            y_q,         y_d;
    colour_t               colour_q,    colour_d;
    logic [3:0]            cnt_q,       cnt_d;
    logic [3:0]            delay_q,     delay_d;
    logic [PRESCALE_W-1:0] presc_q,     presc_d;
    logic [7:0]            vga_x_q,     vga_x_d;
    logic [6:0]            vga_y_q,     vga_y_d;
    colour_t               vga_col_q,   vga_col_d;
    logic                  vga_plot_q,  vga_plot_d;

    assign en = (num[0] == choice);

    enemy_lfsr #(
        .SEED   (LFSR_SEED)
    ) u_lfsr (
        .clock  (clock),
        .resetn (resetn),
        .en_i   (en),
        .lfsr_o (lfsr)
    );

    // Fold the 0..255 LFSR range onto legal sprite columns 0..X_MAX.
    assign x_rand     = (lfsr > X_MAX) ? (lfsr - c_X_SPAN) : lfsr;
    assign px         = x_q + {6'd0, cnt_q[1:0]};
    assign py         = y_q + {5'd0, cnt_q[3:2]};
    assign pix_colour = load_black ? COLOUR_BLACK : colour_q;

    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        colour_d   = colour_q;
        cnt_d      = cnt_q;
        delay_d    = delay_q;
        presc_d    = presc_q;
        vga_x_d    = vga_x_q;
        vga_y_d    = vga_y_q;
        vga_col_d  = vga_col_q;
        vga_plot_d = 1'b0;

        if (en) begin
            if (load_colour) begin
                colour_d = colour_in;
            end

            if (en_reset) begin
                x_d = X_INIT;
                y_d = Y_INIT;
            end else begin
                if (loadX) begin
                    x_d = x_rand;
                end
                if (loadY) begin
                    y_d = (y_q == Y_BOTTOM) ? Y_INIT : (y_q + 7'd1);
                end
            end

            if (en_reset) begin
                cnt_d = 4'd0;
            end else if (en_counter) begin
                cnt_d = cnt_q + 4'd1;
            end

            // delay_cnt ticks on prescaler wrap and saturates at 15.
            if (en_reset || !reset_delay) begin
                presc_d = '0;
                delay_d = 4'd0;
            end else if (en_delay_counter) begin
                presc_d = presc_q + 1'b1;
                if ((&presc_q) && (delay_q != 4'd15)) begin
                    delay_d = delay_q + 4'd1;
                end
            end

            vga_x_d    = px;
            vga_y_d    = py;
            vga_col_d  = pix_colour;
            vga_plot_d = plot;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            x_q        <= X_INIT;
            y_q        <= Y_INIT;
            colour_q   <= COLOUR_BLACK;
            cnt_q      <= 4'd0;
            delay_q    <= 4'd0;
            presc_q    <= '0;
            vga_x_q    <= 8'd0;
            vga_y_q    <= 7'd0;
            vga_col_q  <= COLOUR_BLACK;
            vga_plot_q <= 1'b0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            colour_q   <= colour_d;
            cnt_q      <= cnt_d;
            delay_q    <= delay_d;
            presc_q    <= presc_d;
            vga_x_q    <= vga_x_d;
            vga_y_q    <= vga_y_d;
            vga_col_q  <= vga_col_d;
            vga_plot_q <= vga_plot_d;
        end
    end

    assign X          = x_q;
    assign Y          = y_q;
    assign cnt        = cnt_q;
    assign delay_cnt  = delay_q;
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_col_q;
    assign vga_plot   = vga_plot_q;

endmodule

`default_nettype wire

// File: tb/tb_enemy2_datapath.sv
// ============================================================================
// Module      : tb_enemy2_datapath
// Description : Scoreboard bench for enemy2_datapath (PRESCALE_W = 2).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_enemy2_datapath;

    logic       clock = 1'b0;
    logic       resetn, choice;
    logic [1:0] num;
    logic [2:0] colour_in;
    logic       loadX, loadY, load_colour, load_black, plot;
    logic       en_counter, en_delay_counter, reset_delay, en_reset;
    logic [7:0] X, vga_x;
    logic [6:0] Y, vga_y;
    logic [3:0] cnt, delay_cnt;
    logic [2:0] vga_colour;
    logic       vga_plot;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic       p;
    } pix_t;

    pix_t       sb[$];
    logic [7:0] lfsr_m;

    always #5 clock = ~clock;

    enemy2_datapath #(
        .PRESCALE_W (2)
    ) dut (
        .clock            (clock),
        .resetn           (resetn),
        .choice           (choice),
        .num              (num),
        .colour_in        (colour_in),
        .loadX            (loadX),
        .loadY            (loadY),
        .load_colour      (load_colour),
        .load_black       (load_black),
        .plot             (plot),
        .en_counter       (en_counter),
        .en_delay_counter (en_delay_counter),
        .reset_delay      (reset_delay),
        .en_reset         (en_reset),
        .X                (X),
        .Y                (Y),
        .cnt              (cnt),
        .delay_cnt        (delay_cnt),
        .vga_x            (vga_x),
        .vga_y            (vga_y),
        .vga_colour       (vga_colour),
        .vga_plot         (vga_plot)
    );

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
    endfunction

    function automatic logic [7:0] map_x(input logic [7:0] s);
        return (s > 8'd156) ? (s - 8'd157) : s;
    endfunction

    // Reference LFSR: reseeds on reset, steps on every lane-enabled cycle.
    always @(posedge clock) begin
        if (!resetn)                lfsr_m <= 8'hA5;
        else if (num[0] == choice)  lfsr_m <= lfsr_next(lfsr_m);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_strobes();
        loadX = 0; loadY = 0; load_colour = 0; load_black = 0; plot = 0;
        en_counter = 0; en_delay_counter = 0; en_reset = 0;
    endtask

    task automatic draw(input logic blk, input logic [7:0] x0, input logic [6:0] y0,
                        input logic [2:0] col);
        pix_t e, got;
        plot = 1; en_counter = 1; load_black = blk;
        for (int k = 0; k < 16; k++) begin
            e.x = x0 + 8'(k % 4);
            e.y = y0 + 7'(k / 4);
            e.c = blk ? 3'b000 : col;
            e.p = 1'b1;
            sb.push_back(e);
            if (k == 15) chk("cnt_at_15", cnt, 15);
            tick();
            got = sb.pop_front();
            chk("draw_x", vga_x, got.x);
            chk("draw_y", vga_y, got.y);
            chk("draw_col", vga_colour, got.c);
            chk("draw_plot", vga_plot, got.p);
        end
        plot = 0; en_counter = 0; load_black = 0;
        chk("cnt_wrap", cnt, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] exp_x;
        resetn = 0; choice = 0; num = 2'b00; colour_in = 3'b000; reset_delay = 0;
        clear_strobes();
        tick(); tick();
        chk("rst_X", X, 20);
        chk("rst_Y", Y, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_delay", delay_cnt, 0);
        chk("rst_plot", vga_plot, 0);
        chk("rst_vga_x", vga_x, 0);
        resetn = 1;

        colour_in = 3'b100; load_colour = 1; tick(); load_colour = 0;
        loadY = 1; repeat (5) tick(); loadY = 0;
        chk("preset_Y", Y, 5);
        draw(1'b0, 8'd20, 7'd5, 3'b100);
        draw(1'b1, 8'd20, 7'd5, 3'b100);

        reset_delay = 1; en_delay_counter = 1;
        for (int n = 1; n <= 70; n++) begin
            tick();
            chk("delay_run", delay_cnt, (n / 4 > 15) ? 15 : n / 4);
        end
        reset_delay = 0; tick();
        chk("delay_clear", delay_cnt, 0);
        en_delay_counter = 0;

        loadY = 1; repeat (105) tick(); loadY = 0;
        chk("Y_bottom", Y, 110);
        loadX = 1; loadY = 1; exp_x = map_x(lfsr_m);
        tick();
        loadX = 0; loadY = 0;
        chk("wrap_Y", Y, 0);
        chk("wrap_X", X, exp_x);
        chk("wrap_X_legal", (X <= 8'd156), 1);

        loadY = 1; en_counter = 1; repeat (3) tick();
        chk("pre_rst_Y", Y, 3);
        en_reset = 1; loadX = 1;
        tick();
        clear_strobes();
        chk("enrst_Y", Y, 0);
        chk("enrst_X", X, 20);
        chk("enrst_cnt", cnt, 0);

        reset_delay = 1; en_delay_counter = 1; repeat (4) tick(); en_delay_counter = 0;
        chk("delay_one", delay_cnt, 1);
        plot = 1; en_counter = 1; tick();
        chk("pre_gate_plot", vga_plot, 1);
        chk("pre_gate_x", vga_x, 20);
        chk("pre_gate_col", vga_colour, 4);

        num = 2'b01; choice = 0;
        loadX = 1; loadY = 1; load_colour = 1; load_black = 1; colour_in = 3'b111;
        en_reset = 1; reset_delay = 0; en_delay_counter = 1; plot = 1; en_counter = 1;
        tick();
        chk("gate_X", X, 20);
        chk("gate_Y", Y, 0);
        chk("gate_cnt", cnt, 1);
        chk("gate_delay", delay_cnt, 1);
        chk("gate_plot", vga_plot, 0);
        chk("gate_vga_x", vga_x, 20);
        chk("gate_col", vga_colour, 4);

        num = 2'b00; clear_strobes(); reset_delay = 1; plot = 1; loadX = 1;
        exp_x = map_x(lfsr_m);
        tick();
        loadX = 0;
        chk("post_gate_col", vga_colour, 4);
        chk("post_gate_x", vga_x, 21);
        chk("post_gate_X", X, exp_x);
        chk("post_gate_delay", delay_cnt, 1);

        en_counter = 1; repeat (6) tick();
        chk("mid_cnt", cnt, 7);
        resetn = 0; tick();
        chk("mid_rst_X", X, 20);
        chk("mid_rst_Y", Y, 0);
        chk("mid_rst_cnt", cnt, 0);
        chk("mid_rst_delay", delay_cnt, 0);
        chk("mid_rst_vx", vga_x, 0);
        chk("mid_rst_vy", vga_y, 0);
        chk("mid_rst_col", vga_colour, 0);
        chk("mid_rst_plot", vga_plot, 0);

        resetn = 1; clear_strobes(); plot = 1; loadX = 1;
        exp_x = map_x(lfsr_m);
        tick();
        chk("reseed_X", X, exp_x);
        chk("reseed_X_val", X, 8);
        chk("post_rst_col", vga_colour, 0);
        chk("post_rst_plot", vga_plot, 1);
        clear_strobes();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
